// File: rtl/crc.sv
// Registered CRC generator: crc_out is the CRC of the word sampled on the previous edge.
// An unrolled MSB-first remainder network feeds one CRC_W-bit output register.
module crc #(
    parameter int                 DATA_W = 16,
    parameter int                 CRC_W  = 8,
    parameter logic [CRC_W-1:0]   POLY   = 8'hB3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_p0;
    logic [CRC_W-1:0] crc_p1;

    // The loop fully unrolls into an XOR network; initial remainder 0, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] word);
        logic [CRC_W-1:0] rem;
        logic             fb;
        rem = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = rem[CRC_W-1] ^ word[i];
            rem = {rem[CRC_W-2:0], 1'b0};
            if (fb) begin
                rem = rem ^ POLY;
            end
        end
        return rem;
    endfunction

    assign crc_p0 = crc_calc(data);

    // Stage p0 -> p1: the only state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_p1 <= '0;
        end else begin
            crc_p1 <= crc_p0;
        end
    end

    assign crc_out = crc_p1;

endmodule

// File: tb/tb_crc.sv
// Self-checking bench for crc: directed vectors plus a randomized run against a
// polynomial long-division reference model.
module tb_crc;

    localparam int               DATA_W = 16;
    localparam int               CRC_W  = 8;
    localparam logic [CRC_W-1:0] POLY   = 8'hB3;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data;
    logic [CRC_W-1:0]  crc_out;

    int checks = 0;
    int errors = 0;

    crc #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .crc_out (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CRC_W-1:0] got, input logic [CRC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Remainder of (word * x^CRC_W) divided by the full generator {1, POLY} over GF(2).
    function automatic logic [CRC_W-1:0] ref_crc(input logic [DATA_W-1:0] word);
        logic [DATA_W+CRC_W-1:0] dividend;
        logic [DATA_W+CRC_W-1:0] gen;
        dividend = {word, {CRC_W{1'b0}}};
        gen      = {{(DATA_W-1){1'b0}}, 1'b1, POLY};
        for (int b = DATA_W + CRC_W - 1; b >= CRC_W; b--) begin
            if (dividend[b]) begin
                dividend = dividend ^ (gen << (b - CRC_W));
            end
        end
        return dividend[CRC_W-1:0];
    endfunction

    // Present a word, clock it in, and sample one time unit after the edge.
    task automatic apply(input logic [DATA_W-1:0] word);
        data = word;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_check(input string tag, input logic [DATA_W-1:0] word, input logic [CRC_W-1:0] exp);
        apply(word);
        check(tag, crc_out, exp);
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        logic [CRC_W-1:0]  held;

        rst_n = 1'b0;
        data  = 16'hFFFF;
        #1;
        check("reset_t0", crc_out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", crc_out, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", crc_out, 8'h00);
        @(posedge clk);
        #1;
        check("reset_first_edge", crc_out, 8'hDB);

        apply_check("bit0",   16'h0001, 8'hB3);
        apply_check("bit1",   16'h0002, 8'hD5);
        apply_check("bit8",   16'h0100, 8'h8C);
        apply_check("bit15",  16'h8000, 8'hEF);
        apply_check("zero",   16'h0000, 8'h00);
        apply_check("ones",   16'hFFFF, 8'hDB);
        apply_check("linear", 16'h0101, 8'h3F);

        apply_check("stream0", 16'h0001, 8'hB3);
        apply_check("stream1", 16'h8000, 8'hEF);
        apply_check("stream2", 16'hFFFF, 8'hDB);
        apply_check("stream3", 16'h0000, 8'h00);

        // Hold a word, then disturb data between edges: output must not follow.
        apply_check("hold_a", 16'h1234, ref_crc(16'h1234));
        held = crc_out;
        @(posedge clk);
        #1;
        check("hold_b", crc_out, held);
        data = 16'hA5A5;
        #2;
        check("no_comb_path", crc_out, held);
        @(posedge clk);
        #1;
        check("after_change", crc_out, ref_crc(16'hA5A5));

        for (int i = 0; i < 200; i++) begin
            w = DATA_W'($urandom);
            apply_check("random", w, ref_crc(w));
            if (i == 100) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_reset_mid", crc_out, 8'h00);
                #1;
                rst_n = 1'b1;
                #1;
                check("async_release_no_stale", crc_out, 8'h00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
